// File: rtl/load_store_unit_pkg.sv
// Shared encodings for the RV32I load/store path: decode-stage memory controls,
// LSU state codes and the access-legality check.
package load_store_unit_pkg;

    localparam logic [1:0] MEM_OP_NONE  = 2'b00;
    localparam logic [1:0] MEM_OP_LOAD  = 2'b01;
    localparam logic [1:0] MEM_OP_STORE = 2'b10;

    localparam logic [2:0] MEM_RD_NONE = 3'd0;
    localparam logic [2:0] MEM_RD_BYTE = 3'd1;
    localparam logic [2:0] MEM_RD_HALF = 3'd2;
    localparam logic [2:0] MEM_RD_WORD = 3'd3;
    localparam logic [2:0] MEM_RD_B_U  = 3'd4;
    localparam logic [2:0] MEM_RD_H_U  = 3'd5;

    localparam logic [3:0] MEM_WR_NONE = 4'b0000;
    localparam logic [3:0] MEM_WR_BYTE = 4'b0001;
    localparam logic [3:0] MEM_WR_HALF = 4'b0011;
    localparam logic [3:0] MEM_WR_WORD = 4'b1111;

    localparam logic [1:0] LSU_ST_IDLE = 2'd0;
    localparam logic [1:0] LSU_ST_REQ  = 2'd1;
    localparam logic [1:0] LSU_ST_WAIT = 2'd2;
    localparam logic [1:0] LSU_ST_DONE = 2'd3;

    localparam int unsigned LSU_TIMEOUT_DEFAULT = 255;

    // Unknown read types, odd write masks and unknown ops are all rejected.
    function automatic logic access_legal(input logic [1:0] op, input logic [2:0] rtype,
                                          input logic [3:0] mask, input logic [1:0] off);
        logic ok;
        ok = 1'b0;
        if (op == MEM_OP_LOAD) begin
            case (rtype)
                MEM_RD_BYTE, MEM_RD_B_U: ok = 1'b1;
                MEM_RD_HALF, MEM_RD_H_U: ok = !off[0];
                MEM_RD_WORD:             ok = (off == 2'b00);
                default:                 ok = 1'b0;
            endcase
        end else if (op == MEM_OP_STORE) begin
            case (mask)
                MEM_WR_BYTE: ok = 1'b1;
                MEM_WR_HALF: ok = !off[0];
                MEM_WR_WORD: ok = (off == 2'b00);
                default:     ok = 1'b0;
            endcase
        end
        return ok;
    endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Data-memory bus: one request/grant handshake followed by a read-data beat for loads.
interface load_store_unit_if;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_gnt;
    logic        bus_rvalid;
    logic [31:0] bus_rdata;

    modport master (output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
                    input  bus_gnt, bus_rvalid, bus_rdata);
    modport slave  (input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
                    output bus_gnt, bus_rvalid, bus_rdata);
endinterface

// File: rtl/load_store_unit_extender.sv
// Picks the addressed byte/half out of a read word and sign- or zero-extends it.
module load_extender
    import load_store_unit_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  off,
    input  logic [2:0]  rtype,
    output logic [31:0] ext
);
    logic [31:0] shifted;

    always_comb begin
        shifted = rdata >> {off, 3'b000};
        case (rtype)
            MEM_RD_BYTE: ext = {{24{shifted[7]}}, shifted[7:0]};
            MEM_RD_B_U:  ext = {24'd0, shifted[7:0]};
            MEM_RD_HALF: ext = {{16{shifted[15]}}, shifted[15:0]};
            MEM_RD_H_U:  ext = {16'd0, shifted[15:0]};
            default:     ext = rdata;
        endcase
    end
endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit: one bus transaction per memory instruction, stalling the
// core via busy and returning extended load data with a one-cycle done pulse.
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = LSU_TIMEOUT_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        core_valid,
    input  logic [1:0]  mem_op,
    input  logic [2:0]  mem_read_type,
    input  logic [3:0]  mem_write_mask,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [31:0] rdata,
    load_store_unit_if.master mem
);
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

    logic [1:0]  state_q, state_d;
    logic [15:0] cnt_q;
    logic [1:0]  op_q;
    logic [2:0]  rtype_q;
    logic [1:0]  off_q;
    logic        accept, legal, expired;
    logic [3:0]  be_sh;
    logic [31:0] wdata_rep, ext_data;

    assign busy    = (state_q != LSU_ST_IDLE);
    assign accept  = (state_q == LSU_ST_IDLE) && core_valid && (mem_op != MEM_OP_NONE);
    assign legal   = access_legal(mem_op, mem_read_type, mem_write_mask, addr[1:0]);
    // >= rather than == so a load granted on its last REQ cycle still times out in WAIT.
    assign expired = (cnt_q >= TMO_LAST);
    assign be_sh   = mem_write_mask << addr[1:0];

    always_comb begin
        case (mem_write_mask)
            MEM_WR_BYTE: wdata_rep = {4{wdata[7:0]}};
            MEM_WR_HALF: wdata_rep = {2{wdata[15:0]}};
            default:     wdata_rep = wdata;
        endcase
    end

    load_extender u_ext (
        .rdata (mem.bus_rdata),
        .off   (off_q),
        .rtype (rtype_q),
        .ext   (ext_data)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            LSU_ST_IDLE: if (accept) state_d = legal ? LSU_ST_REQ : LSU_ST_DONE;
            LSU_ST_REQ: begin
                if (mem.bus_gnt) state_d = (op_q == MEM_OP_STORE) ? LSU_ST_DONE : LSU_ST_WAIT;
                else if (expired) state_d = LSU_ST_DONE;
            end
            LSU_ST_WAIT: if (mem.bus_rvalid || expired) state_d = LSU_ST_DONE;
            default:     state_d = LSU_ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= LSU_ST_IDLE;
            cnt_q         <= '0;
            op_q          <= MEM_OP_NONE;
            rtype_q       <= MEM_RD_NONE;
            off_q         <= '0;
            done          <= 1'b0;
            err           <= 1'b0;
            rdata         <= '0;
            mem.bus_req   <= 1'b0;
            mem.bus_we    <= 1'b0;
            mem.bus_addr  <= '0;
            mem.bus_be    <= '0;
            mem.bus_wdata <= '0;
        end else begin
            state_q <= state_d;
            done    <= (state_d == LSU_ST_DONE);
            err     <= 1'b0;
            rdata   <= '0;
            if (state_q == LSU_ST_REQ || state_q == LSU_ST_WAIT) cnt_q <= cnt_q + 16'd1;
            case (state_q)
                LSU_ST_IDLE: if (accept) begin
                    op_q    <= mem_op;
                    rtype_q <= mem_read_type;
                    off_q   <= addr[1:0];
                    if (legal) begin
                        cnt_q         <= '0;
                        mem.bus_req   <= 1'b1;
                        mem.bus_we    <= (mem_op == MEM_OP_STORE);
                        mem.bus_addr  <= {addr[31:2], 2'b00};
                        mem.bus_be    <= be_sh;
                        mem.bus_wdata <= wdata_rep;
                    end else begin
                        err <= 1'b1;
                    end
                end
                LSU_ST_REQ: if (mem.bus_gnt || expired) begin
                    mem.bus_req <= 1'b0;
                    err         <= !mem.bus_gnt;
                end
                LSU_ST_WAIT: begin
                    // Data arriving on the expiry cycle still completes cleanly.
                    if (mem.bus_rvalid) rdata <= ext_data;
                    else if (expired)   err   <= 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit; runs the DUT with a 4-cycle timeout.
module tb_load_store_unit;
    import load_store_unit_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        core_valid;
    logic [1:0]  mem_op;
    logic [2:0]  mem_read_type;
    logic [3:0]  mem_write_mask;
    logic [31:0] addr, wdata;
    logic        busy, done, err;
    logic [31:0] rdata;
    int          n_chk = 0;
    int          n_fail = 0;

    load_store_unit_if mem_if ();

    load_store_unit #(.TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .rst_n(rst_n), .core_valid(core_valid), .mem_op(mem_op),
        .mem_read_type(mem_read_type), .mem_write_mask(mem_write_mask),
        .addr(addr), .wdata(wdata), .busy(busy), .done(done), .err(err),
        .rdata(rdata), .mem(mem_if)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(negedge clk);
    endtask

    task automatic core(input logic [1:0] op, input logic [2:0] rt, input logic [3:0] mk,
                        input logic [31:0] a, input logic [31:0] wd);
        core_valid = 1'b1; mem_op = op; mem_read_type = rt; mem_write_mask = mk;
        addr = a; wdata = wd;
    endtask

    task automatic core_idle();
        core_valid = 1'b0; mem_op = MEM_OP_NONE; mem_read_type = MEM_RD_NONE;
        mem_write_mask = MEM_WR_NONE; addr = '0; wdata = '0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; core_idle();
        mem_if.bus_gnt = 1'b0; mem_if.bus_rvalid = 1'b0; mem_if.bus_rdata = '0;
        step(); step();
        n_chk++; if ({busy, done, err, mem_if.bus_req, mem_if.bus_we} !== 5'b0) begin
            n_fail++; $display("FAIL reset_ctrl: got %b want 00000", {busy, done, err, mem_if.bus_req, mem_if.bus_we}); end
        n_chk++; if ({rdata, mem_if.bus_addr, mem_if.bus_be, mem_if.bus_wdata} !== 100'd0) begin
            n_fail++; $display("FAIL reset_data: got %h want 0", {rdata, mem_if.bus_addr, mem_if.bus_be, mem_if.bus_wdata}); end
        rst_n = 1'b1;
        core(MEM_OP_NONE, MEM_RD_BYTE, MEM_WR_NONE, 32'h10, 32'h0);   // MEM_OP_NONE must be ignored
        step(); step();
        core_idle();
        n_chk++; if ({busy, done, mem_if.bus_req} !== 3'b000) begin
            n_fail++; $display("FAIL op_none_ignored: got %b want 000", {busy, done, mem_if.bus_req}); end
    endtask

    task automatic test_store_byte();
        core(MEM_OP_STORE, MEM_RD_NONE, MEM_WR_BYTE, 32'h1003, 32'h0000_00A5);
        mem_if.bus_gnt = 1'b1;
        step(); core_idle();
        n_chk++; if ({busy, done, mem_if.bus_req, mem_if.bus_we} !== 4'b1011) begin
            n_fail++; $display("FAIL sb_c1_ctrl: got %b want 1011", {busy, done, mem_if.bus_req, mem_if.bus_we}); end
        n_chk++; if (mem_if.bus_addr !== 32'h1000) begin
            n_fail++; $display("FAIL sb_addr: got %h want 00001000", mem_if.bus_addr); end
        n_chk++; if (mem_if.bus_be !== 4'b1000) begin
            n_fail++; $display("FAIL sb_be: got %b want 1000", mem_if.bus_be); end
        n_chk++; if (mem_if.bus_wdata !== 32'hA5A5_A5A5) begin
            n_fail++; $display("FAIL sb_wdata: got %h want a5a5a5a5", mem_if.bus_wdata); end
        step(); mem_if.bus_gnt = 1'b0;
        n_chk++; if ({done, err, busy, mem_if.bus_req, rdata} !== {4'b1010, 32'd0}) begin
            n_fail++; $display("FAIL sb_done: got %h want %h", {done, err, busy, mem_if.bus_req, rdata}, {4'b1010, 32'd0}); end
        step();
        n_chk++; if ({done, busy} !== 2'b00) begin
            n_fail++; $display("FAIL sb_idle: got %b want 00", {done, busy}); end
    endtask

    task automatic run_load(input string nm, input logic [2:0] rt, input logic [31:0] a,
                            input logic [31:0] word, input logic [31:0] exp);
        core(MEM_OP_LOAD, rt, MEM_WR_NONE, a, 32'h0);
        mem_if.bus_gnt = 1'b1;
        step(); core_idle();
        n_chk++; if ({busy, mem_if.bus_req, mem_if.bus_we, done, mem_if.bus_addr} !== {4'b1100, a[31:2], 2'b00}) begin
            n_fail++; $display("FAIL %s_req: got %h want %h", nm, {busy, mem_if.bus_req, mem_if.bus_we, done, mem_if.bus_addr}, {4'b1100, a[31:2], 2'b00}); end
        step();
        mem_if.bus_gnt = 1'b0; mem_if.bus_rvalid = 1'b1; mem_if.bus_rdata = word;
        n_chk++; if ({busy, mem_if.bus_req, done} !== 3'b100) begin
            n_fail++; $display("FAIL %s_wait: got %b want 100", nm, {busy, mem_if.bus_req, done}); end
        step();
        mem_if.bus_rvalid = 1'b0; mem_if.bus_rdata = '0;
        n_chk++; if ({done, err, rdata} !== {2'b10, exp}) begin
            n_fail++; $display("FAIL %s_data: got %h want %h", nm, {done, err, rdata}, {2'b10, exp}); end
        step();
        n_chk++; if ({done, busy} !== 2'b00) begin
            n_fail++; $display("FAIL %s_idle: got %b want 00", nm, {done, busy}); end
    endtask

    task automatic test_loads();
        run_load("lb",     MEM_RD_BYTE, 32'h2001, 32'h0000_80FF, 32'hFFFF_FF80);
        run_load("lbu",    MEM_RD_B_U,  32'h2001, 32'h0000_80FF, 32'h0000_0080);
        run_load("lb_off3", MEM_RD_BYTE, 32'h2003, 32'h7F00_0000, 32'h0000_007F);
        run_load("lh",     MEM_RD_HALF, 32'h3002, 32'h8001_1234, 32'hFFFF_8001);
        run_load("lhu",    MEM_RD_H_U,  32'h3002, 32'h8001_1234, 32'h0000_8001);
        run_load("lh_off0", MEM_RD_HALF, 32'h3000, 32'h8001_1234, 32'h0000_1234);
    endtask

    task automatic test_illegal();
        logic [1:0]  ops [5] = '{MEM_OP_LOAD, MEM_OP_STORE, MEM_OP_LOAD, MEM_OP_STORE, MEM_OP_LOAD};
        logic [2:0]  rts [5] = '{MEM_RD_WORD, MEM_RD_NONE, MEM_RD_NONE, MEM_RD_NONE, MEM_RD_H_U};
        logic [3:0]  mks [5] = '{MEM_WR_NONE, MEM_WR_HALF, MEM_WR_NONE, MEM_WR_NONE, MEM_WR_NONE};
        logic [31:0] ads [5] = '{32'h3002, 32'h0001, 32'h0000, 32'h0000, 32'h0003};
        for (int i = 0; i < 5; i++) begin
            core(ops[i], rts[i], mks[i], ads[i], 32'hFFFF_FFFF);
            step(); core_idle();
            n_chk++; if ({done, err, busy, mem_if.bus_req, rdata} !== {4'b1110, 32'd0}) begin
                n_fail++; $display("FAIL illegal_%0d: got %h want %h", i, {done, err, busy, mem_if.bus_req, rdata}, {4'b1110, 32'd0}); end
            step();
            n_chk++; if ({done, err, busy, mem_if.bus_req} !== 4'b0000) begin
                n_fail++; $display("FAIL illegal_%0d_after: got %b want 0000", i, {done, err, busy, mem_if.bus_req}); end
        end
    endtask

    task automatic test_gnt_wait();
        core(MEM_OP_STORE, MEM_RD_NONE, MEM_WR_WORD, 32'h4000, 32'hDEAD_BEEF);
        mem_if.bus_gnt = 1'b0;
        step(); core_idle();
        for (int k = 1; k <= 3; k++) begin
            n_chk++; if ({mem_if.bus_req, mem_if.bus_we, done, mem_if.bus_addr, mem_if.bus_be, mem_if.bus_wdata}
                         !== {3'b110, 32'h4000, 4'hF, 32'hDEAD_BEEF}) begin
                n_fail++; $display("FAIL sw_hold_%0d: got %h want %h", k,
                    {mem_if.bus_req, mem_if.bus_we, done, mem_if.bus_addr, mem_if.bus_be, mem_if.bus_wdata},
                    {3'b110, 32'h4000, 4'hF, 32'hDEAD_BEEF}); end
            step();
        end
        mem_if.bus_gnt = 1'b1;   // granted on the timeout cycle: grant wins
        n_chk++; if ({mem_if.bus_req, done} !== 2'b10) begin
            n_fail++; $display("FAIL sw_gnt_cycle: got %b want 10", {mem_if.bus_req, done}); end
        step(); mem_if.bus_gnt = 1'b0;
        n_chk++; if ({done, err, mem_if.bus_req} !== 3'b100) begin
            n_fail++; $display("FAIL sw_done: got %b want 100", {done, err, mem_if.bus_req}); end
        step();
    endtask

    task automatic test_coincident();
        core(MEM_OP_LOAD, MEM_RD_WORD, MEM_WR_NONE, 32'h5000, 32'h0);
        step(); core_idle();
        mem_if.bus_rvalid = 1'b1; mem_if.bus_rdata = 32'h3333_3333;   // stray in REQ
        step();
        mem_if.bus_gnt = 1'b1; mem_if.bus_rdata = 32'h1111_1111;      // coincident with gnt
        step();
        mem_if.bus_gnt = 1'b0; mem_if.bus_rvalid = 1'b0;
        n_chk++; if ({busy, done, mem_if.bus_req} !== 3'b100) begin
            n_fail++; $display("FAIL lw_coinc_wait: got %b want 100", {busy, done, mem_if.bus_req}); end
        step();
        mem_if.bus_rvalid = 1'b1; mem_if.bus_rdata = 32'h2222_2222;   // lands on the expiry cycle
        n_chk++; if (done !== 1'b0) begin
            n_fail++; $display("FAIL lw_coinc_early: got %b want 0", done); end
        step();
        mem_if.bus_rvalid = 1'b0; mem_if.bus_rdata = '0;
        n_chk++; if ({done, err, rdata} !== {2'b10, 32'h2222_2222}) begin
            n_fail++; $display("FAIL lw_expiry_data: got %h want %h", {done, err, rdata}, {2'b10, 32'h2222_2222}); end
        step();
    endtask

    task automatic test_timeout();
        core(MEM_OP_LOAD, MEM_RD_BYTE, MEM_WR_NONE, 32'h6000, 32'h0);
        mem_if.bus_gnt = 1'b1;
        step(); core_idle();
        step(); mem_if.bus_gnt = 1'b0;
        for (int k = 2; k <= 4; k++) begin
            n_chk++; if ({busy, done} !== 2'b10) begin
                n_fail++; $display("FAIL tmo_ld_c%0d: got %b want 10", k, {busy, done}); end
            step();
        end
        n_chk++; if ({done, err, mem_if.bus_req, rdata} !== {3'b110, 32'd0}) begin
            n_fail++; $display("FAIL tmo_ld_err: got %h want %h", {done, err, mem_if.bus_req, rdata}, {3'b110, 32'd0}); end
        mem_if.bus_rvalid = 1'b1; mem_if.bus_rdata = 32'hFFFF_FFFF;   // late response
        step(); step();
        mem_if.bus_rvalid = 1'b0; mem_if.bus_rdata = '0;
        n_chk++; if ({done, err, busy} !== 3'b000) begin
            n_fail++; $display("FAIL tmo_stray: got %b want 000", {done, err, busy}); end
        run_load("lw_after_tmo", MEM_RD_WORD, 32'h7000, 32'hCAFE_F00D, 32'hCAFE_F00D);

        core(MEM_OP_STORE, MEM_RD_NONE, MEM_WR_WORD, 32'h4004, 32'h1);
        step(); core_idle();
        step(); step(); step();
        n_chk++; if ({mem_if.bus_req, done} !== 2'b10) begin
            n_fail++; $display("FAIL tmo_st_last: got %b want 10", {mem_if.bus_req, done}); end
        step();
        n_chk++; if ({done, err, mem_if.bus_req} !== 3'b110) begin
            n_fail++; $display("FAIL tmo_st_err: got %b want 110", {done, err, mem_if.bus_req}); end
        step();
    endtask

    task automatic test_back_to_back();
        core(MEM_OP_STORE, MEM_RD_NONE, MEM_WR_HALF, 32'h8002, 32'h0000_1234);
        step();
        core(MEM_OP_STORE, MEM_RD_NONE, MEM_WR_BYTE, 32'h9001, 32'h0000_005A);   // held while busy
        n_chk++; if ({mem_if.bus_addr, mem_if.bus_be, mem_if.bus_wdata} !== {32'h8000, 4'b1100, 32'h1234_1234}) begin
            n_fail++; $display("FAIL sh_bus: got %h want %h", {mem_if.bus_addr, mem_if.bus_be, mem_if.bus_wdata}, {32'h8000, 4'b1100, 32'h1234_1234}); end
        mem_if.bus_gnt = 1'b1;
        step(); mem_if.bus_gnt = 1'b0;
        n_chk++; if ({done, err, mem_if.bus_addr} !== {2'b10, 32'h8000}) begin
            n_fail++; $display("FAIL sh_done: got %h want %h", {done, err, mem_if.bus_addr}, {2'b10, 32'h8000}); end
        step();
        n_chk++; if ({busy, done, mem_if.bus_req} !== 3'b000) begin
            n_fail++; $display("FAIL b2b_idle: got %b want 000", {busy, done, mem_if.bus_req}); end
        step(); core_idle();
        n_chk++; if ({mem_if.bus_req, mem_if.bus_addr, mem_if.bus_be, mem_if.bus_wdata} !== {1'b1, 32'h9000, 4'b0010, 32'h5A5A_5A5A}) begin
            n_fail++; $display("FAIL b2b_second: got %h want %h", {mem_if.bus_req, mem_if.bus_addr, mem_if.bus_be, mem_if.bus_wdata}, {1'b1, 32'h9000, 4'b0010, 32'h5A5A_5A5A}); end
        mem_if.bus_gnt = 1'b1;
        step(); mem_if.bus_gnt = 1'b0;
        n_chk++; if ({done, err} !== 2'b10) begin
            n_fail++; $display("FAIL b2b_done: got %b want 10", {done, err}); end
        step();
    endtask

    task automatic test_reset_mid();
        core(MEM_OP_LOAD, MEM_RD_WORD, MEM_WR_NONE, 32'h2000, 32'h0);
        mem_if.bus_gnt = 1'b1;
        step(); core_idle();
        step(); mem_if.bus_gnt = 1'b0;
        n_chk++; if (busy !== 1'b1) begin
            n_fail++; $display("FAIL rst_wait_pre: got %b want 1", busy); end
        rst_n = 1'b0; #1;
        n_chk++; if ({busy, done, mem_if.bus_req} !== 3'b000) begin
            n_fail++; $display("FAIL rst_wait_async: got %b want 000", {busy, done, mem_if.bus_req}); end
        rst_n = 1'b1;
        mem_if.bus_rvalid = 1'b1; mem_if.bus_rdata = 32'h1234_5678;
        step(); mem_if.bus_rvalid = 1'b0;
        n_chk++; if ({done, busy, rdata} !== 34'd0) begin
            n_fail++; $display("FAIL rst_wait_resp: got %h want 0", {done, busy, rdata}); end

        core(MEM_OP_STORE, MEM_RD_NONE, MEM_WR_WORD, 32'h4000, 32'h55);
        step(); core_idle();
        n_chk++; if (mem_if.bus_req !== 1'b1) begin
            n_fail++; $display("FAIL rst_req_pre: got %b want 1", mem_if.bus_req); end
        rst_n = 1'b0; #1;
        n_chk++; if ({mem_if.bus_req, busy} !== 2'b00) begin
            n_fail++; $display("FAIL rst_req_async: got %b want 00", {mem_if.bus_req, busy}); end
        rst_n = 1'b1; mem_if.bus_gnt = 1'b1;
        step(); mem_if.bus_gnt = 1'b0;
        n_chk++; if ({done, busy, mem_if.bus_req} !== 3'b000) begin
            n_fail++; $display("FAIL rst_req_gnt: got %b want 000", {done, busy, mem_if.bus_req}); end
    endtask

    initial begin
        test_reset();
        test_store_byte();
        test_loads();
        test_illegal();
        test_gnt_wait();
        test_coincident();
        test_timeout();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
